// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: opcode field position, HALT encoding and the fetch FSM states.
package fetch_pkg;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/instr_fetch_unit.sv
// PC owner and BRAM address driver; word returns one cycle after its address, 1 instr/cycle.
// Backpressure: instr_ready low re-issues the same address so the output word holds until accepted.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  accept;
  logic                  halt_hit;

  // A redirect squashes whatever word is on the output this cycle.
  assign instr_valid = inflight_q & ~redirect_valid;
  assign accept      = instr_valid & instr_ready;
  assign halt_hit    = accept && (state_q == RUN) &&
                       (imem_dout[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
  assign pc_inc      = fetch_pc_q + 1'b1;

  assign instr_out   = imem_dout;
  assign instr_pc    = fetch_pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    imem_addr = fetch_pc_q;
    if (redirect_valid) begin
      state_d   = RUN;
      imem_addr = redirect_pc;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          // A HALT word parks the PC on itself so resume can continue at pc_halt+1.
          if (halt_hit)    state_d   = HALTED;
          else if (accept) imem_addr = pc_inc;
        end
        HALTED: begin
          if (start) begin
            state_d   = RUN;
            imem_addr = pc_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= imem_addr;
      inflight_q <= (state_d == RUN);
      if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural BRAM + transaction-level fetch model, plus directed literal checks.
module tb_instr_fetch_unit;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int CW   = 5;
  localparam int CMAX = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [DW-1:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(8'h00), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which word sits on the output, whether it is real, and how many were taken.
  logic [AW-1:0] m_pc;
  bit            m_have, m_halted, m_idle;
  int            m_cnt;

  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      m_pc = 8'h00; m_have = 0; m_halted = 0; m_idle = 1; m_cnt = 0;
      chk("m_rst_valid", 32'(instr_valid), 32'd0);
      chk("m_rst_addr",  32'(imem_addr),   32'd0);
      chk("m_rst_count", 32'(fetch_count), 32'd0);
    end else begin
      chk("m_valid", 32'(instr_valid), 32'(m_have && !redirect_valid));
      if (m_have && !redirect_valid) begin
        chk("m_pc",  32'(instr_pc), 32'(m_pc));
        chk("m_out", instr_out,     mem[m_pc]);
      end
      chk("m_halted", 32'(halted),      32'(m_halted));
      chk("m_count",  32'(fetch_count), 32'(m_cnt));
      if (redirect_valid) begin
        m_pc = redirect_pc; m_have = 1; m_halted = 0; m_idle = 0;
      end else if (m_have) begin
        if (instr_ready) begin
          if (m_cnt < CMAX) m_cnt++;
          if (mem[m_pc][31:26] == 6'h3f) begin
            m_have = 0; m_halted = 1;
          end else begin
            m_pc = m_pc + 8'd1;
          end
        end
      end else if (start && (m_idle || m_halted)) begin
        if (m_halted) m_pc = m_pc + 8'd1;
        m_have = 1; m_idle = 0; m_halted = 0;
      end
      // The address issued now is exactly the word expected on the output next cycle.
      chk("m_addr", 32'(imem_addr), 32'(m_pc));
    end
  end

  task automatic step(input bit st, input bit rv, input logic [AW-1:0] rpc, input bit rdy);
    @(negedge clk);
    start = st; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
    mem[3] = 32'hFC00_0000;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); rst = 1'b0;
    #3;
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted),      32'd0);
    chk("rst_addr",   32'(imem_addr),   32'd0);
    chk("rst_count",  32'(fetch_count), 32'd0);

    step(1, 0, 0, 1); #3;
    chk("start_valid", 32'(instr_valid), 32'd0);
    chk("start_addr",  32'(imem_addr),   32'd0);
    step(0, 0, 0, 1); #3;
    chk("seq_pc0", 32'(instr_pc), 32'h00);
    chk("seq_out0", instr_out, 32'h1000_0000);
    step(0, 0, 0, 1); #3;
    chk("seq_pc1", 32'(instr_pc), 32'h01);
    step(0, 0, 0, 1); #3;
    chk("seq_pc2", 32'(instr_pc), 32'h02);
    step(0, 0, 0, 1); #3;
    chk("halt_pc",    32'(instr_pc),    32'h03);
    chk("halt_word",  instr_out,        32'hFC00_0000);
    chk("count3",     32'(fetch_count), 32'd3);
    step(0, 0, 0, 1); #3;
    chk("halted_hi",  32'(halted),      32'd1);
    chk("halted_val", 32'(instr_valid), 32'd0);
    chk("count4",     32'(fetch_count), 32'd4);

    step(1, 0, 0, 1); #3;
    chk("resume_addr", 32'(imem_addr), 32'h04);
    step(1, 0, 0, 1); #3;
    chk("resume_pc", 32'(instr_pc), 32'h04);

    step(0, 1, 8'h00, 1); #3;
    chk("redir_squash", 32'(instr_valid), 32'd0);
    chk("count5",       32'(fetch_count), 32'd5);
    step(0, 0, 0, 1); #3;
    chk("redir_pc0", 32'(instr_pc), 32'h00);

    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0); #3;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc",    32'(instr_pc),    32'h01);
      chk("stall_out",   instr_out,        32'h1001_0203);
    end
    step(0, 0, 0, 1); #3;
    chk("release_pc", 32'(instr_pc), 32'h01);
    step(0, 0, 0, 1); #3;
    chk("after_pc2", 32'(instr_pc), 32'h02);
    step(0, 1, 8'h08, 1); #3;
    chk("halt_squash", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 1); #3;
    chk("no_halt",   32'(halted),   32'd0);
    chk("tgt8_pc",   32'(instr_pc), 32'h08);
    chk("tgt8_out",  instr_out,     32'h1008_1018);
    chk("count8",    32'(fetch_count), 32'd8);

    step(0, 1, 8'h00, 1);
    step(0, 0, 0, 1);
    step(0, 1, 8'h08, 1); #3;
    chk("redir1_squash", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 1); #3;
    chk("redir1_pc",   32'(instr_pc),    32'h08);
    chk("redir1_cnt",  32'(fetch_count), 32'd10);

    step(0, 1, 8'hFF, 1);
    step(0, 0, 0, 1); #3;
    chk("wrap_ff", 32'(instr_pc), 32'hFF);
    step(0, 0, 0, 1); #3;
    chk("wrap_00", 32'(instr_pc), 32'h00);

    step(0, 1, 8'h10, 1);
    for (int k = 0; k < 40; k++) step(0, 0, 0, 1);
    step(0, 0, 0, 1); #3;
    chk("sat_count", 32'(fetch_count), 32'd31);

    step(0, 0, 0, 1); #2;
    rst = 1'b1; #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_addr",  32'(imem_addr),   32'd0);
    chk("arst_count", 32'(fetch_count), 32'd0);
    chk("arst_halt",  32'(halted),      32'd0);
    step(0, 0, 0, 1); rst = 1'b0;
    step(1, 0, 0, 1);
    step(0, 0, 0, 1); #3;
    chk("restart_pc",  32'(instr_pc), 32'h00);
    chk("restart_out", instr_out,     32'h1000_0000);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    @(negedge clk); #6;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
